// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues single-outstanding imem requests,
// and drives the IF/ID register with redirect, stall and flush handling.
module fetch_stage #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_if,
  input  logic            stall_id,
  input  logic            flush_id,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc_plus4,
  output logic [31:0]     if_id_instr,
  output logic            if_id_valid
);

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD
  } state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic [XLEN-1:0] pc_plus4;
  logic            drop, drop_n;
  logic [31:0]     hold_instr, hold_n;
  logic            load;
  logic [31:0]     load_instr;
  logic            accept;

  assign pc_plus4       = pc + XLEN'(4);
  assign imem_req_valid = rst_n && (state == REQ) && !stall_if;
  assign imem_req_addr  = pc;
  assign accept         = imem_req_valid && imem_req_ready;

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    drop_n     = drop;
    hold_n     = hold_instr;
    load       = 1'b0;
    load_instr = imem_rsp_data;
    if (PCSrc) begin
      // Redirect wins; a fetch in flight becomes wrong-path
      pc_n = branch_target;
      unique case (state)
        REQ: begin
          if (accept) begin
            drop_n  = 1'b1;
            state_n = WAIT;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            drop_n  = 1'b0;
            state_n = REQ;
          end else begin
            drop_n = 1'b1;
          end
        end
        HOLD:    state_n = REQ;
        default: state_n = REQ;
      endcase
    end else begin
      unique case (state)
        REQ: begin
          if (accept) state_n = WAIT;
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            if (drop) begin
              drop_n  = 1'b0;
              state_n = REQ;
            end else if (!stall_id) begin
              load    = 1'b1;
              pc_n    = pc_plus4;
              state_n = REQ;
            end else begin
              hold_n  = imem_rsp_data;
              state_n = HOLD;
            end
          end
        end
        HOLD: begin
          load_instr = hold_instr;
          if (!stall_id) begin
            load    = 1'b1;
            pc_n    = pc_plus4;
            state_n = REQ;
          end
        end
        default: state_n = REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= REQ;
      pc             <= RESET_PC;
      drop           <= 1'b0;
      hold_instr     <= NOP_INSTR;
      if_id_pc       <= '0;
      if_id_pc_plus4 <= XLEN'(4);
      if_id_instr    <= NOP_INSTR;
      if_id_valid    <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      drop       <= drop_n;
      hold_instr <= hold_n;
      if (flush_id) begin
        if_id_valid <= 1'b0;
        if_id_instr <= NOP_INSTR;
      end else if (!stall_id) begin
        if (load) begin
          if_id_pc       <= pc;
          if_id_pc_plus4 <= pc_plus4;
          if_id_instr    <= load_instr;
          if_id_valid    <= 1'b1;
        end else begin
          if_id_valid <= 1'b0;
          if_id_instr <= NOP_INSTR;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: cycle table plus hand sequences,
// with a small imem model of programmable response latency.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_if, stall_id, flush_id, PCSrc;
  logic [31:0] branch_target;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] if_id_pc, if_id_pc_plus4, if_id_instr;
  logic        if_id_valid;

  int          checks   = 0;
  int          failures = 0;

  logic        pend  = 1'b0;
  logic        inj   = 1'b0;
  int          pcnt  = 0;
  int          lat   = 1;
  logic [31:0] paddr = '0;

  typedef struct {
    logic        sif, sid, fl, br;
    logic [31:0] tgt;
    logic        rdy;
    int          lat;
    logic        erv;
    logic [31:0] eaddr;
    logic        ev;
    logic [31:0] epc;
  } vec_t;

  vec_t tbl[$];

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n),
    .stall_if(stall_if), .stall_id(stall_id),
    .flush_id(flush_id), .PCSrc(PCSrc),
    .branch_target(branch_target),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .if_id_pc(if_id_pc),
    .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_instr(if_id_instr),
    .if_id_valid(if_id_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_A5A5;
  endfunction

  function automatic vec_t mk(
    input logic sif, sid, fl, br,
    input logic [31:0] tgt,
    input logic rdy, input int l,
    input logic erv, input logic [31:0] eaddr,
    input logic ev, input logic [31:0] epc
  );
    vec_t v;
    v.sif = sif; v.sid = sid; v.fl = fl; v.br = br;
    v.tgt = tgt; v.rdy = rdy; v.lat = l;
    v.erv = erv; v.eaddr = eaddr;
    v.ev = ev; v.epc = epc;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic sif, sid, fl, br,
                        input logic [31:0] tgt,
                        input logic rdy, input int l);
    stall_if       = sif;
    stall_id       = sid;
    flush_id       = fl;
    PCSrc          = br;
    branch_target  = tgt;
    imem_req_ready = rdy;
    lat            = l;
  endtask

  task automatic drive_rsp();
    imem_rsp_valid = inj || (pend && pcnt == 0);
    imem_rsp_data  = inj ? 32'hDEAD_BEEF : mem_word(paddr);
  endtask

  task automatic advance();
    logic        acc, fired;
    logic [31:0] a;
    acc   = imem_req_valid && imem_req_ready;
    a     = imem_req_addr;
    fired = pend && pcnt == 0 && !inj;
    @(posedge clk);
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (fired) pend = 1'b0;
      else if (pend && pcnt > 0) pcnt--;
      if (acc) begin
        pend  = 1'b1;
        pcnt  = lat - 1;
        paddr = a;
      end
    end
    @(negedge clk);
    inj = 1'b0;
  endtask

  task automatic do_cycle(input string tag,
                          input logic erv, input logic [31:0] eaddr,
                          input logic ev, input logic [31:0] epc);
    drive_rsp();
    #1;
    chk({tag, " req_valid"}, 32'(imem_req_valid), 32'(erv));
    if (erv) chk({tag, " req_addr"}, imem_req_addr, eaddr);
    chk({tag, " if_id_valid"}, 32'(if_id_valid), 32'(ev));
    chk({tag, " if_id_instr"}, if_id_instr, ev ? mem_word(epc) : NOP);
    if (ev) begin
      chk({tag, " if_id_pc"}, if_id_pc, epc);
      chk({tag, " if_id_pc_plus4"}, if_id_pc_plus4, epc + 32'd4);
    end
    advance();
  endtask

  initial begin
    // sif sid fl br tgt rdy lat | erv addr | ev pc
    tbl.push_back(mk(0,0,0,0,0,1,1, 1,32'h000, 0,0));
    tbl.push_back(mk(0,0,0,0,0,1,1, 0,0,       0,0));
    tbl.push_back(mk(0,0,0,0,0,1,1, 1,32'h004, 1,32'h000));
    tbl.push_back(mk(0,0,0,0,0,1,1, 0,0,       0,0));
    tbl.push_back(mk(0,0,0,0,0,1,1, 1,32'h008, 1,32'h004));
    tbl.push_back(mk(0,1,0,0,0,1,1, 0,0,       0,0));
    tbl.push_back(mk(0,1,0,0,0,1,1, 0,0,       0,0));
    tbl.push_back(mk(0,1,0,0,0,1,1, 0,0,       0,0));
    tbl.push_back(mk(0,0,0,0,0,1,1, 0,0,       0,0));
    tbl.push_back(mk(0,0,0,0,0,1,1, 1,32'h00C, 1,32'h008));
    tbl.push_back(mk(0,0,0,0,0,1,1, 0,0,       0,0));
    tbl.push_back(mk(0,0,0,0,0,1,3, 1,32'h010, 1,32'h00C));
    tbl.push_back(mk(0,0,0,1,32'h100,1,1, 0,0, 0,0));
    tbl.push_back(mk(0,0,0,0,0,1,1, 0,0,       0,0));
    tbl.push_back(mk(0,0,0,0,0,1,1, 0,0,       0,0));
    tbl.push_back(mk(0,0,0,0,0,1,1, 1,32'h100, 0,0));
    tbl.push_back(mk(0,0,0,0,0,1,1, 0,0,       0,0));
    tbl.push_back(mk(0,1,0,1,32'h020,1,1, 1,32'h104, 1,32'h100));
    tbl.push_back(mk(0,1,0,0,0,1,1, 0,0,       1,32'h100));
    tbl.push_back(mk(0,1,0,0,0,1,1, 1,32'h020, 1,32'h100));
    tbl.push_back(mk(0,1,1,1,32'h200,1,1, 0,0, 1,32'h100));
    tbl.push_back(mk(0,0,0,0,0,0,1, 1,32'h200, 0,0));
    tbl.push_back(mk(1,0,0,0,0,1,1, 0,0,       0,0));
    tbl.push_back(mk(1,0,0,0,0,1,1, 0,0,       0,0));
    tbl.push_back(mk(0,0,0,1,32'h300,0,1, 1,32'h200, 0,0));
    tbl.push_back(mk(0,0,0,0,0,1,1, 1,32'h300, 0,0));
    tbl.push_back(mk(0,0,0,0,0,1,1, 0,0,       0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1, 1,32'h304, 1,32'h300));

    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 32'h0, 0, 1);
    @(negedge clk);
    drive_rsp();
    advance();
    advance();

    drive_rsp();
    #1;
    chk("reset req_valid", 32'(imem_req_valid), 32'd0);
    chk("reset if_id_valid", 32'(if_id_valid), 32'd0);
    chk("reset if_id_instr", if_id_instr, NOP);
    chk("reset if_id_pc", if_id_pc, 32'h0);
    chk("reset if_id_pc_plus4", if_id_pc_plus4, 32'h4);
    advance();

    rst_n = 1'b1;
    foreach (tbl[i]) begin
      set_in(tbl[i].sif, tbl[i].sid, tbl[i].fl, tbl[i].br,
             tbl[i].tgt, tbl[i].rdy, tbl[i].lat);
      do_cycle($sformatf("row%0d", i), tbl[i].erv, tbl[i].eaddr,
               tbl[i].ev, tbl[i].epc);
    end

    // PC wrap at the top of the address space
    set_in(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 1);
    do_cycle("wrap_redir", 1, 32'h304, 0, 0);
    set_in(0, 0, 0, 0, 0, 1, 1);
    do_cycle("wrap_req", 1, 32'hFFFF_FFFC, 0, 0);
    do_cycle("wrap_rsp", 0, 0, 0, 0);
    set_in(0, 0, 0, 0, 0, 1, 3);
    do_cycle("wrap_out", 1, 32'h0, 1, 32'hFFFF_FFFC);

    // Reset while waiting, then a late response lands in REQ
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 1, 1);
    do_cycle("rst_wait", 0, 0, 0, 0);
    rst_n = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 1);
    inj = 1'b1;
    do_cycle("late_rsp", 1, 32'h0, 0, 0);
    set_in(0, 0, 0, 0, 0, 1, 1);
    do_cycle("post_rst_req", 1, 32'h0, 0, 0);
    do_cycle("post_rst_rsp", 0, 0, 0, 0);
    set_in(0, 0, 0, 0, 0, 0, 1);
    do_cycle("post_rst_out", 1, 32'h4, 1, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage: owns the PC, issues requests to instruction memory over a valid/ready request channel, and drives the IF/ID pipeline register consumed by decode.
- Obeys the pipeline control signals stall_if, stall_id, flush_id and PCSrc/branch_target from the EX-stage branch logic.
- Supports variable-latency memory with one outstanding request.
- Discards wrong-path responses after a redirect.

Parameters:
- XLEN, 32, data/address width.
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INSTR, 32'h0000_0013, instruction word driven into IF/ID when empty or flushed (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- stall_if  in  1  block issue of new fetch requests.
- stall_id  in  1  hold IF/ID register contents.
- flush_id  in  1  invalidate IF/ID register.
- PCSrc  in  1  redirect: branch/jump taken in EX.
- branch_target  in  XLEN  redirect PC.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  fetch address (= pc).
- imem_rsp_valid  in  1  response valid, exactly one per accepted request, ≥1 cycle after acceptance.
- imem_rsp_data  in  32  instruction word.
- if_id_pc  out  XLEN  PC of instruction in IF/ID.
- if_id_pc_plus4  out  XLEN  if_id_pc + 4.
- if_id_instr  out  32  instruction in IF/ID.
- if_id_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (rst_n=0 at posedge):
  - pc=RESET_PC; state=REQ; drop=0; buffer empty.
  - if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc_plus4=4.
  - imem_req_valid is 0 while rst_n=0 (combinational gate).
- Reset mid-operation: any in-flight response arriving after reset release is ignored, because drop is forced to 0 and state to REQ; the memory is also reset by the same rst_n.
- FSM states REQ, WAIT, HOLD.
  - REQ: imem_req_valid = !stall_if; imem_req_addr = pc. On valid&&ready, go to WAIT.
  - WAIT: imem_req_valid=0. On imem_rsp_valid:
    - drop=1: clear drop, go to REQ; pc unchanged.
    - stall_id=0: load IF/ID {pc, pc+4, rsp_data, valid=1}; pc<=pc+4; go to REQ.
    - stall_id=1: capture rsp_data into buffer, go to HOLD.
  - HOLD: when stall_id=0, load IF/ID from buffer with pc; pc<=pc+4; go to REQ.
- Fetch latency: the earliest a response can reach IF/ID is 2 cycles after the request is issued (one-cycle accept plus one-cycle response).
- Redirect (PCSrc=1) has highest priority over everything except reset. pc<=branch_target, then by state:
  - REQ, request accepted this cycle: drop<=1, go to WAIT.
  - REQ, not accepted: stay in REQ. The address changes to the target on the next cycle; abandoning an unaccepted request is legal on this interface.
  - WAIT, rsp_valid this cycle: discard response, go to REQ.
  - WAIT, no rsp_valid: drop<=1, stay in WAIT.
  - HOLD: discard buffer, go to REQ.
  - A redirect never loads a valid instruction into IF/ID in the same cycle.
- flush_id: if_id_valid<=0, if_id_instr<=NOP_INSTR; overrides both stall_id and any same-cycle load.
- stall_id=1 without flush: IF/ID unchanged; pc never advances.
- IF/ID write with no instruction available: when stall_id=0, flush_id=0 and nothing is loaded this cycle, write a bubble (valid=0, NOP_INSTR).
- stall_if only gates request issue; a pending response is still captured per the WAIT/HOLD rules.
- PC arithmetic: modulo 2^XLEN; wrap from 32'hFFFF_FFFC to 0 is legal. pc[1:0] is not checked.
- At most one outstanding request at any time. The block never asserts imem_req_valid in WAIT or HOLD.

Test Plan:
- Reset release, memory 1-cycle latency, ready=1, no stalls -> requests at 0x0, 0x4, 0x8 every 2 cycles; if_id_pc 0x0 then 0x4 with correct instr; if_id_valid pulses between bubbles; reset values checked at cycle 0.
- Response for 0x8 arrives with stall_id=1 held 3 cycles -> state HOLD, IF/ID unchanged for 3 cycles, then if_id_pc=0x8 with buffered instr; no request issued while held.
- PCSrc=1 with branch_target=0x100 while in WAIT (response for 0x10 arrives 2 cycles later) -> 0x10 response dropped, if_id_valid stays 0, next request addr=0x100, first valid if_id_pc=0x100.
- PCSrc=1 and flush_id=1 in the same cycle as rsp_valid for 0x20 -> response discarded; IF/ID=bubble (valid=0, 0x00000013); next request addr=branch_target.
- stall_if=1 in REQ with ready=1 for 2 cycles -> imem_req_valid=0 for those cycles; request at unchanged pc afterwards.
- pc=0xFFFF_FFFC fetched, no stall -> if_id_pc_plus4=0x0; next request addr=0x0. rst_n=0 asserted in WAIT -> next request at RESET_PC; late response ignored.
